multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control FSM for the 8-bit accumulator-style processor datapath (13-bit PC/TR, 8-bit IR, 5-bit DI, 4-entry register file, CZN flags, single shared memory). It sits beside the datapath and receives the latched opcode and the jump-condition result. It drives every register load, mux select and memory strobe so that each instruction executes over 2–4 clock cycles.

## Interface
No parameters.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- instruction  input  4  opcode, IR[7:4]
- jump_taken  input  1  condition result from jump selector (DI[2:1] vs CZN)
- ld_PC / ld_IR / ld_DI / ld_TR  output  1 each  register loads
- ld_ALU  output  1  ALU result register load
- ld_CZN  output  1  flag register load
- sel_PC_src_JUMP  output  1  PC mux: 1 = TR, 0 = PC+1
- sel_MEM_src_PC / sel_MEM_src_TR  output  1 each  memory address select, one-hot
- MEM_read / MEM_write  output  1 each  memory strobes
- sel_IR_3_2 / sel_DI_4_3  output  1 each  RF dest/read_reg2 select, one-hot
- write_reg_en  output  1  RF write enable
- sel_RF_write_src_TR_12_5 / sel_RF_write_src_reg1 / sel_RF_write_src_ALU  output  1 each  RF write-data select, one-hot
- sel_ALU_src_reg1 / sel_ALU_src_TR  output  1 each  ALU operand A select, one-hot
- sel_CZN_src_ALU / sel_CZN_src_RF  output  1 each  flag source select
- halted  output  1  high in HALT

## Operation
Opcode map:
- 0000 LDA: two-byte, rd ← mem[TR]
- 0001 STA: two-byte, mem[TR] ← rd
- 0010 JMP: two-byte
- 0011 BR: two-byte, conditional
- 01xx: one-byte reg-reg ALU op
- 10xx: two-byte ALU op with immediate TR[12:5]
- 1100 MOV
- 1101 NOP
- 111x HALT

Any output not listed for a state is 0. Outputs are Moore, except in DECODE (decoded from `instruction`) and BR (`jump_taken`).

States and transitions:
- FETCH: MEM_read, sel_MEM_src_PC, ld_IR, ld_PC (sel_PC_src_JUMP=0). → DECODE.
- DECODE: ld_DI. For two-byte ops, also MEM_read, sel_MEM_src_PC, ld_TR, ld_PC. Next state:
  - 0000 → LDA1, 0001 → STA, 0010 → JMP, 0011 → BR, 10xx → ALUI
  - 01xx → ALU, 1100 → MOV, 1101 → FETCH, 111x → HALT
- LDA1: MEM_read, sel_MEM_src_TR, ld_TR. → LDA2.
- LDA2: write_reg_en, sel_DI_4_3, sel_RF_write_src_TR_12_5. → FETCH.
- STA: MEM_write, sel_MEM_src_TR, sel_DI_4_3. → FETCH.
- JMP: ld_PC, sel_PC_src_JUMP. → FETCH.
- BR: ld_PC and sel_PC_src_JUMP both equal jump_taken. → FETCH.
- ALU: sel_IR_3_2, sel_ALU_src_reg1, ld_ALU, ld_CZN, sel_CZN_src_ALU. → WB.
- ALUI: sel_DI_4_3, sel_ALU_src_TR, ld_ALU, ld_CZN, sel_CZN_src_ALU. → WBI.
- WB: write_reg_en, sel_IR_3_2, sel_RF_write_src_ALU. → FETCH.
- WBI: write_reg_en, sel_DI_4_3, sel_RF_write_src_ALU. → FETCH.
- MOV: write_reg_en, sel_IR_3_2, sel_RF_write_src_reg1, ld_CZN, sel_CZN_src_RF. → FETCH.
- HALT: halted=1, all other outputs 0; stays until rst.

Invariants:
- Each one-hot select group has at most one bit high in every cycle.
- MEM_read and MEM_write are never high together.
- write_reg_en and MEM_write are never high together.

## Timing
- rst high: state forced to FETCH asynchronously. All outputs, including halted, are forced 0 while rst is high.
- The first FETCH cycle is the first rising edge after rst deasserts.
- Reset mid-instruction aborts it; no partial writes occur after rst asserts.
- Cycles per instruction:
  - NOP: 2
  - STA, JMP, BR, MOV: 3
  - LDA, ALU, ALUI: 4
- The PC advances by 1 in FETCH and again in DECODE for two-byte ops.
- Jump targets load in the JMP/BR cycle and are fetched in the next cycle.
- `instruction` is sampled only in DECODE. `jump_taken` is sampled only in BR; it is don't-care elsewhere.
- sel_PC_src_JUMP is 0 in every state except JMP and taken BR. This keeps a stale jump_taken from corrupting PC+1 loads.
- Flags update only in the ALU, ALUI and MOV cycles.

## Test plan
- Reset then release, instruction=1101 held → FETCH, DECODE, FETCH… repeating. ld_IR pulses every 2 cycles, ld_TR never pulses, halted=0.
- Opcode 0000 → 4-cycle sequence:
  - DECODE: MEM_read + ld_TR + ld_PC
  - LDA1: MEM_read + sel_MEM_src_TR + ld_TR
  - LDA2: write_reg_en + sel_RF_write_src_TR_12_5
- Opcode 0011:
  - jump_taken=1 → ld_PC=1 and sel_PC_src_JUMP=1 in cycle 3.
  - jump_taken=0 → both 0 in cycle 3.
  - jump_taken=1 during FETCH → sel_PC_src_JUMP stays 0.
- Opcode 0101 → ld_ALU + ld_CZN + sel_CZN_src_ALU in cycle 3, write_reg_en + sel_RF_write_src_ALU in cycle 4, then FETCH.
- Opcode 1110 → halted=1 from cycle 3 and stays 1 for 20 cycles with every other output 0. Asserting rst clears it; FETCH follows release.
- Assert rst asynchronously mid-STA (between clock edges) → MEM_write drops to 0 immediately. Random opcode streams checked every cycle for one-hot and mutual-exclusion violations → zero violations.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 8-bit accumulator datapath: sequences register
// loads, mux selects and memory strobes so each instruction takes 2-4 cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | read mem[PC] into IR, PC <= PC+1
// DECODE | load DI; two-byte ops also read mem[PC] into TR, PC <= PC+1
// LDA1   | read mem[TR] into TR
// LDA2   | write TR[12:5] to rd
// STA    | write rd to mem[TR]
// JMP    | PC <= TR
// BR     | PC <= TR when jump_taken
// ALU    | reg-reg ALU op, latch result and flags
// ALUI   | ALU op with immediate TR, latch result and flags
// WB     | write ALU result to IR[3:2] register
// WBI    | write ALU result to DI[4:3] register
// MOV    | copy reg1 to dest, flags from RF
// HALT   | parked until reset
module multicycle_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] instruction,
    input  logic       jump_taken,
    output logic       ld_PC,
    output logic       ld_IR,
    output logic       ld_DI,
    output logic       ld_TR,
    output logic       ld_ALU,
    output logic       ld_CZN,
    output logic       sel_PC_src_JUMP,
    output logic       sel_MEM_src_PC,
    output logic       sel_MEM_src_TR,
    output logic       MEM_read,
    output logic       MEM_write,
    output logic       sel_IR_3_2,
    output logic       sel_DI_4_3,
    output logic       write_reg_en,
    output logic       sel_RF_write_src_TR_12_5,
    output logic       sel_RF_write_src_reg1,
    output logic       sel_RF_write_src_ALU,
    output logic       sel_ALU_src_reg1,
    output logic       sel_ALU_src_TR,
    output logic       sel_CZN_src_ALU,
    output logic       sel_CZN_src_RF,
    output logic       halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_LDA1, S_LDA2, S_STA, S_JMP, S_BR,
        S_ALU, S_ALUI, S_WB, S_WBI, S_MOV, S_HALT
    } state_t;

    state_t state;
    state_t state_nx;
    logic   two_byte;

    assign two_byte = (instruction[3:2] == 2'b00) || (instruction[3:2] == 2'b10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                casez (instruction)
                    4'b0000: state_nx = S_LDA1;
                    4'b0001: state_nx = S_STA;
                    4'b0010: state_nx = S_JMP;
                    4'b0011: state_nx = S_BR;
                    4'b01??: state_nx = S_ALU;
                    4'b10??: state_nx = S_ALUI;
                    4'b1100: state_nx = S_MOV;
                    4'b1101: state_nx = S_FETCH;
                    default: state_nx = S_HALT;
                endcase
            end
            S_LDA1:   state_nx = S_LDA2;
            S_ALU:    state_nx = S_WB;
            S_ALUI:   state_nx = S_WBI;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Outputs are gated by rst so nothing strobes while reset is held,
    // even though the state register already sits in FETCH.
    always_comb begin
        ld_PC = 1'b0;  ld_IR = 1'b0;  ld_DI = 1'b0;  ld_TR = 1'b0;
        ld_ALU = 1'b0; ld_CZN = 1'b0; sel_PC_src_JUMP = 1'b0;
        sel_MEM_src_PC = 1'b0; sel_MEM_src_TR = 1'b0;
        MEM_read = 1'b0; MEM_write = 1'b0;
        sel_IR_3_2 = 1'b0; sel_DI_4_3 = 1'b0; write_reg_en = 1'b0;
        sel_RF_write_src_TR_12_5 = 1'b0; sel_RF_write_src_reg1 = 1'b0;
        sel_RF_write_src_ALU = 1'b0;
        sel_ALU_src_reg1 = 1'b0; sel_ALU_src_TR = 1'b0;
        sel_CZN_src_ALU = 1'b0; sel_CZN_src_RF = 1'b0;
        halted = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    MEM_read = 1'b1; sel_MEM_src_PC = 1'b1;
                    ld_IR = 1'b1;    ld_PC = 1'b1;
                end
                S_DECODE: begin
                    ld_DI = 1'b1;
                    if (two_byte) begin
                        MEM_read = 1'b1; sel_MEM_src_PC = 1'b1;
                        ld_TR = 1'b1;    ld_PC = 1'b1;
                    end
                end
                S_LDA1: begin
                    MEM_read = 1'b1; sel_MEM_src_TR = 1'b1; ld_TR = 1'b1;
                end
                S_LDA2: begin
                    write_reg_en = 1'b1; sel_DI_4_3 = 1'b1;
                    sel_RF_write_src_TR_12_5 = 1'b1;
                end
                S_STA: begin
                    MEM_write = 1'b1; sel_MEM_src_TR = 1'b1; sel_DI_4_3 = 1'b1;
                end
                S_JMP: begin
                    ld_PC = 1'b1; sel_PC_src_JUMP = 1'b1;
                end
                S_BR: begin
                    ld_PC = jump_taken; sel_PC_src_JUMP = jump_taken;
                end
                S_ALU: begin
                    sel_IR_3_2 = 1'b1; sel_ALU_src_reg1 = 1'b1;
                    ld_ALU = 1'b1; ld_CZN = 1'b1; sel_CZN_src_ALU = 1'b1;
                end
                S_ALUI: begin
                    sel_DI_4_3 = 1'b1; sel_ALU_src_TR = 1'b1;
                    ld_ALU = 1'b1; ld_CZN = 1'b1; sel_CZN_src_ALU = 1'b1;
                end
                S_WB: begin
                    write_reg_en = 1'b1; sel_IR_3_2 = 1'b1; sel_RF_write_src_ALU = 1'b1;
                end
                S_WBI: begin
                    write_reg_en = 1'b1; sel_DI_4_3 = 1'b1; sel_RF_write_src_ALU = 1'b1;
                end
                S_MOV: begin
                    write_reg_en = 1'b1; sel_IR_3_2 = 1'b1; sel_RF_write_src_reg1 = 1'b1;
                    ld_CZN = 1'b1; sel_CZN_src_RF = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: halted = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed per-cycle vector table, reset corner
// cases, and random opcode streams against a per-opcode micro-op model.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] instruction;
    logic       jump_taken;
    logic ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN, sel_PC_src_JUMP;
    logic sel_MEM_src_PC, sel_MEM_src_TR, MEM_read, MEM_write;
    logic sel_IR_3_2, sel_DI_4_3, write_reg_en;
    logic sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1, sel_RF_write_src_ALU;
    logic sel_ALU_src_reg1, sel_ALU_src_TR, sel_CZN_src_ALU, sel_CZN_src_RF, halted;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .instruction(instruction), .jump_taken(jump_taken),
        .ld_PC(ld_PC), .ld_IR(ld_IR), .ld_DI(ld_DI), .ld_TR(ld_TR),
        .ld_ALU(ld_ALU), .ld_CZN(ld_CZN), .sel_PC_src_JUMP(sel_PC_src_JUMP),
        .sel_MEM_src_PC(sel_MEM_src_PC), .sel_MEM_src_TR(sel_MEM_src_TR),
        .MEM_read(MEM_read), .MEM_write(MEM_write),
        .sel_IR_3_2(sel_IR_3_2), .sel_DI_4_3(sel_DI_4_3), .write_reg_en(write_reg_en),
        .sel_RF_write_src_TR_12_5(sel_RF_write_src_TR_12_5),
        .sel_RF_write_src_reg1(sel_RF_write_src_reg1),
        .sel_RF_write_src_ALU(sel_RF_write_src_ALU),
        .sel_ALU_src_reg1(sel_ALU_src_reg1), .sel_ALU_src_TR(sel_ALU_src_TR),
        .sel_CZN_src_ALU(sel_CZN_src_ALU), .sel_CZN_src_RF(sel_CZN_src_RF),
        .halted(halted)
    );

    always #5 clk = ~clk;

    localparam logic [21:0] M_LD_PC   = 22'h1 << 0;
    localparam logic [21:0] M_LD_IR   = 22'h1 << 1;
    localparam logic [21:0] M_LD_DI   = 22'h1 << 2;
    localparam logic [21:0] M_LD_TR   = 22'h1 << 3;
    localparam logic [21:0] M_LD_ALU  = 22'h1 << 4;
    localparam logic [21:0] M_LD_CZN  = 22'h1 << 5;
    localparam logic [21:0] M_PC_JMP  = 22'h1 << 6;
    localparam logic [21:0] M_MEM_PC  = 22'h1 << 7;
    localparam logic [21:0] M_MEM_TR  = 22'h1 << 8;
    localparam logic [21:0] M_MEM_RD  = 22'h1 << 9;
    localparam logic [21:0] M_MEM_WR  = 22'h1 << 10;
    localparam logic [21:0] M_IR32    = 22'h1 << 11;
    localparam logic [21:0] M_DI43    = 22'h1 << 12;
    localparam logic [21:0] M_WRE     = 22'h1 << 13;
    localparam logic [21:0] M_RF_TR   = 22'h1 << 14;
    localparam logic [21:0] M_RF_REG1 = 22'h1 << 15;
    localparam logic [21:0] M_RF_ALU  = 22'h1 << 16;
    localparam logic [21:0] M_ALU_R1  = 22'h1 << 17;
    localparam logic [21:0] M_ALU_TR  = 22'h1 << 18;
    localparam logic [21:0] M_CZN_ALU = 22'h1 << 19;
    localparam logic [21:0] M_CZN_RF  = 22'h1 << 20;
    localparam logic [21:0] M_HALTED  = 22'h1 << 21;

    localparam logic [21:0] V_FETCH = M_MEM_RD | M_MEM_PC | M_LD_IR | M_LD_PC;
    localparam logic [21:0] V_DEC1  = M_LD_DI;
    localparam logic [21:0] V_DEC2  = M_LD_DI | M_MEM_RD | M_MEM_PC | M_LD_TR | M_LD_PC;

    logic [21:0] dut_vec;
    assign dut_vec = {halted, sel_CZN_src_RF, sel_CZN_src_ALU, sel_ALU_src_TR,
                      sel_ALU_src_reg1, sel_RF_write_src_ALU, sel_RF_write_src_reg1,
                      sel_RF_write_src_TR_12_5, write_reg_en, sel_DI_4_3, sel_IR_3_2,
                      MEM_write, MEM_read, sel_MEM_src_TR, sel_MEM_src_PC,
                      sel_PC_src_JUMP, ld_CZN, ld_ALU, ld_TR, ld_DI, ld_IR, ld_PC};

    // Reference: the micro-operations each opcode performs in its k-th cycle.
    function automatic int n_cycles(input logic [3:0] op);
        if (op == 4'b1101) return 2;
        if (op == 4'b0001 || op == 4'b0010 || op == 4'b0011 || op == 4'b1100) return 3;
        return 4;
    endfunction

    function automatic logic [21:0] model_vec(input logic [3:0] op, input int k, input logic jt);
        logic two_byte;
        two_byte = (op[3:2] == 2'b00) || (op[3:2] == 2'b10);
        if (k == 0) return V_FETCH;
        if (k == 1) return two_byte ? V_DEC2 : V_DEC1;
        if (op[3:1] == 3'b111) return M_HALTED;
        if (op == 4'b0000)
            return (k == 2) ? (M_MEM_RD | M_MEM_TR | M_LD_TR) : (M_WRE | M_DI43 | M_RF_TR);
        if (op == 4'b0001) return M_MEM_WR | M_MEM_TR | M_DI43;
        if (op == 4'b0010) return M_LD_PC | M_PC_JMP;
        if (op == 4'b0011) return jt ? (M_LD_PC | M_PC_JMP) : 22'h0;
        if (op == 4'b1100) return M_WRE | M_IR32 | M_RF_REG1 | M_LD_CZN | M_CZN_RF;
        if (op[3:2] == 2'b01)
            return (k == 2) ? (M_IR32 | M_ALU_R1 | M_LD_ALU | M_LD_CZN | M_CZN_ALU)
                            : (M_WRE | M_IR32 | M_RF_ALU);
        return (k == 2) ? (M_DI43 | M_ALU_TR | M_LD_ALU | M_LD_CZN | M_CZN_ALU)
                        : (M_WRE | M_DI43 | M_RF_ALU);
    endfunction

    task automatic check_vec(input string name, input logic [21:0] exp);
        logic inv_ok;
        checks++;
        if (dut_vec !== exp) begin
            errors++;
            $display("FAIL %s outputs got %h expected %h (t=%0t)", name, dut_vec, exp, $time);
        end
        inv_ok = ($countones({sel_MEM_src_PC, sel_MEM_src_TR}) <= 1) &&
                 ($countones({sel_IR_3_2, sel_DI_4_3}) <= 1) &&
                 ($countones({sel_RF_write_src_TR_12_5, sel_RF_write_src_reg1,
                              sel_RF_write_src_ALU}) <= 1) &&
                 ($countones({sel_ALU_src_reg1, sel_ALU_src_TR}) <= 1) &&
                 ($countones({sel_CZN_src_ALU, sel_CZN_src_RF}) <= 1) &&
                 !(MEM_read && MEM_write) && !(write_reg_en && MEM_write);
        checks++;
        if (!inv_ok) begin
            errors++;
            $display("FAIL %s invariants got %h expected one-hot/exclusive", name, dut_vec);
        end
    endtask

    // Called just after a rising edge; samples on the falling edge.
    task automatic step(input string name, input logic [3:0] ins, input logic jt,
                        input logic [21:0] exp);
        instruction = ins;
        jump_taken  = jt;
        @(negedge clk);
        check_vec(name, exp);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  ins;
        logic        jt;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] ins, input logic jt, input logic [21:0] exp);
        vec_t v;
        v.ins = ins; v.jt = jt; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0] op;
        logic       jt;

        add(4'd13, 1'b0, V_FETCH); add(4'd13, 1'b0, V_DEC1);
        add(4'd13, 1'b1, V_FETCH); add(4'd13, 1'b1, V_DEC1);
        add(4'd0, 1'b0, V_FETCH);  add(4'd0, 1'b0, V_DEC2);
        add(4'd0, 1'b0, M_MEM_RD | M_MEM_TR | M_LD_TR);
        add(4'd0, 1'b0, M_WRE | M_DI43 | M_RF_TR);
        add(4'd3, 1'b1, V_FETCH);  add(4'd3, 1'b1, V_DEC2);
        add(4'd3, 1'b1, M_LD_PC | M_PC_JMP);
        add(4'd3, 1'b1, V_FETCH);  add(4'd3, 1'b1, V_DEC2);
        add(4'd3, 1'b0, 22'h0);
        add(4'd5, 1'b0, V_FETCH);  add(4'd5, 1'b0, V_DEC1);
        add(4'd5, 1'b0, M_IR32 | M_ALU_R1 | M_LD_ALU | M_LD_CZN | M_CZN_ALU);
        add(4'd5, 1'b0, M_WRE | M_IR32 | M_RF_ALU);
        add(4'd1, 1'b0, V_FETCH);  add(4'd1, 1'b0, V_DEC2);
        add(4'd1, 1'b0, M_MEM_WR | M_MEM_TR | M_DI43);
        add(4'd2, 1'b0, V_FETCH);  add(4'd2, 1'b0, V_DEC2);
        add(4'd2, 1'b0, M_LD_PC | M_PC_JMP);
        add(4'd11, 1'b1, V_FETCH); add(4'd11, 1'b1, V_DEC2);
        add(4'd11, 1'b1, M_DI43 | M_ALU_TR | M_LD_ALU | M_LD_CZN | M_CZN_ALU);
        add(4'd11, 1'b1, M_WRE | M_DI43 | M_RF_ALU);
        add(4'd12, 1'b0, V_FETCH); add(4'd12, 1'b0, V_DEC1);
        add(4'd12, 1'b0, M_WRE | M_IR32 | M_RF_REG1 | M_LD_CZN | M_CZN_RF);

        rst = 1'b1; instruction = 4'd0; jump_taken = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset_held", 22'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tbl[i]) step($sformatf("table_%0d", i), tbl[i].ins, tbl[i].jt, tbl[i].exp);

        // HALT parks for good; only rst gets out.
        step("halt_fetch", 4'd14, 1'b0, V_FETCH);
        step("halt_decode", 4'd14, 1'b0, V_DEC1);
        for (int i = 0; i < 20; i++)
            step("halt_hold", 4'($urandom), 1'($urandom), M_HALTED);
        #2 rst = 1'b1;
        #1 check_vec("halt_rst", 22'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_halt_fetch", 4'd13, 1'b0, V_FETCH);
        step("post_halt_decode", 4'd13, 1'b0, V_DEC1);

        // Abort a store between clock edges.
        step("sta_fetch", 4'd1, 1'b0, V_FETCH);
        step("sta_decode", 4'd1, 1'b0, V_DEC2);
        #1 check_vec("sta_cycle", M_MEM_WR | M_MEM_TR | M_DI43);
        #1 rst = 1'b1;
        #1 check_vec("sta_abort", 22'h0);
        @(posedge clk); #1;
        check_vec("sta_abort_edge", 22'h0);
        rst = 1'b0;
        step("sta_post_fetch", 4'd13, 1'b0, V_FETCH);
        step("sta_post_decode", 4'd13, 1'b0, V_DEC1);

        // Random streams: opcode only valid in DECODE, jump_taken only in cycle 3.
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 13));
            jt = 1'($urandom);
            for (int k = 0; k < n_cycles(op); k++)
                step($sformatf("rand_op%0d_c%0d", op, k),
                     (k == 1) ? op : 4'($urandom),
                     (k == 2) ? jt : 1'($urandom),
                     model_vec(op, k, jt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
